wb_skid_pipe_reg: RTL and testbench

Parametrised successor of the single-channel MEM→WB register. Carries NUM_CH parallel GPR write-back channels from MEM to WB. Uses a valid/ready handshake with a two-entry skid buffer, so backpressure from WB never creates a combinational ready path into MEM. Adds a synchronous flush and drops writes to register 0.

---
 rtl/wb_pipe_pkg.sv | 16 +
 rtl/RegWithWE.sv | 15 +
 rtl/wb_bundle_sanitize.sv | 32 +++
 rtl/wb_skid_pipe_reg.sv | 114 +++++++++++
 tb/tb_wb_skid_pipe_reg.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pipe_pkg.sv
// Shared types and widths for the MEM->WB skid pipeline register.
// Optional same-address squash is selected with WB_SAME_ADDR_SQUASH_EN.
package wb_pipe_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int GPR_ADDR_W = 5;
    localparam int GPR_DATA_W = 32;

    function automatic int entry_w(input int nch, input int aw, input int dw);
        return nch * (1 + aw + dw);
    endfunction
endpackage

// File: rtl/RegWithWE.sv
// Plain register with write enable, cleared by the asynchronous active-low reset.
module RegWithWE #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_we,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)   o_q <= '0;
        else if (i_we) o_q <= i_d;
    end
endmodule

// File: rtl/wb_bundle_sanitize.sv
// Write-enable cleanup applied before a bundle is captured: drops writes to r0,
// and with WB_SAME_ADDR_SQUASH_EN keeps only the highest channel per address.
module wb_bundle_sanitize
    import wb_pipe_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = GPR_ADDR_W
) (
    input  logic [NUM_CH-1:0]        i_we,
    input  logic [NUM_CH*ADDR_W-1:0] i_waddr,
    output logic [NUM_CH-1:0]        o_we
);
    logic [NUM_CH-1:0] w_nz;

    always_comb begin
        w_nz = '0;
        for (int k = 0; k < NUM_CH; k++)
            w_nz[k] = i_we[k] && (i_waddr[k*ADDR_W +: ADDR_W] != '0);
    end

    always_comb begin
        o_we = w_nz;
`ifdef WB_SAME_ADDR_SQUASH_EN
        // A lower channel loses to any higher channel writing the same register.
        for (int j = 0; j < NUM_CH; j++)
            for (int k = j + 1; k < NUM_CH; k++)
                if (w_nz[j] && w_nz[k] &&
                    i_waddr[j*ADDR_W +: ADDR_W] == i_waddr[k*ADDR_W +: ADDR_W])
                    o_we[j] = 1'b0;
`endif
    end
endmodule

// File: rtl/wb_skid_pipe_reg.sv
// NUM_CH-channel MEM->WB register with a two-entry skid buffer and flush.
// Build option WB_SAME_ADDR_SQUASH_EN enables same-address squash in the sanitizer.
module wb_skid_pipe_reg
    import wb_pipe_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = GPR_ADDR_W,
    parameter int DATA_W = GPR_DATA_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NUM_CH-1:0]        i_we,
    input  logic [NUM_CH*ADDR_W-1:0] i_waddr,
    input  logic [NUM_CH*DATA_W-1:0] i_wdata,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [NUM_CH-1:0]        o_we,
    output logic [NUM_CH*ADDR_W-1:0] o_waddr,
    output logic [NUM_CH*DATA_W-1:0] o_wdata
);
    localparam int ENTRY_W = entry_w(NUM_CH, ADDR_W, DATA_W);

    state_e               r_state;
    state_e               w_state_nxt;
    logic                 w_acc;
    logic                 w_rel;
    logic                 w_main_we;
    logic                 w_skid_we;
    logic                 w_main_from_skid;
    logic [NUM_CH-1:0]    w_in_we;
    logic [ENTRY_W-1:0]   w_in_entry;
    logic [ENTRY_W-1:0]   w_main_d;
    logic [ENTRY_W-1:0]   w_main_q;
    logic [ENTRY_W-1:0]   w_skid_q;
    logic [NUM_CH-1:0]    w_main_we_bits;

    wb_bundle_sanitize #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) u_sanitize (
        .i_we    (i_we),
        .i_waddr (i_waddr),
        .o_we    (w_in_we)
    );

    assign w_in_entry = {w_in_we, i_waddr, i_wdata};
    assign w_main_d   = w_main_from_skid ? w_skid_q : w_in_entry;

    // o_ready depends only on the state register, so WB backpressure never
    // reaches MEM combinationally.
    assign o_ready = (r_state != FULL);
    assign o_valid = (r_state != EMPTY);
    assign w_acc   = i_valid & o_ready;
    assign w_rel   = o_valid & i_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= EMPTY;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_we        = 1'b0;
        w_skid_we        = 1'b0;
        w_main_from_skid = 1'b0;
        unique case (r_state)
            EMPTY: if (w_acc) begin
                w_main_we   = 1'b1;
                w_state_nxt = ONE;
            end
            ONE: begin
                if (w_acc && w_rel) begin
                    w_main_we = 1'b1;
                end else if (w_acc) begin
                    w_skid_we   = 1'b1;
                    w_state_nxt = FULL;
                end else if (w_rel) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: if (w_rel) begin
                w_main_we        = 1'b1;
                w_main_from_skid = 1'b1;
                w_state_nxt      = ONE;
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Flush wins over any handshake in the same cycle.
        if (i_flush) begin
            w_state_nxt = EMPTY;
            w_main_we   = 1'b0;
            w_skid_we   = 1'b0;
        end
    end

    RegWithWE #(.W(ENTRY_W)) u_main (
        .clk    (clk),
        .resetn (resetn),
        .i_we   (w_main_we),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    RegWithWE #(.W(ENTRY_W)) u_skid (
        .clk    (clk),
        .resetn (resetn),
        .i_we   (w_skid_we),
        .i_d    (w_in_entry),
        .o_q    (w_skid_q)
    );

    assign {w_main_we_bits, o_waddr, o_wdata} = w_main_q;
    assign o_we = w_main_we_bits & {NUM_CH{o_valid}};
endmodule

// File: tb/tb_wb_skid_pipe_reg.sv
// Directed and randomised checks for wb_skid_pipe_reg (NUM_CH=2, 5-bit addr, 32-bit data).
module tb_wb_skid_pipe_reg;
    localparam int NC = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              i_flush = 1'b0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [NC-1:0]     i_we = '0;
    logic [NC*AW-1:0]  i_waddr = '0;
    logic [NC*DW-1:0]  i_wdata = '0;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic [NC-1:0]     o_we;
    logic [NC*AW-1:0]  o_waddr;
    logic [NC*DW-1:0]  o_wdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NC-1:0]    we;
        logic [NC*AW-1:0] a;
        logic [NC*DW-1:0] d;
    } bund_t;

    wb_skid_pipe_reg #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_we    (i_we),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_we    (o_we),
        .o_waddr (o_waddr),
        .o_wdata (o_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NC-1:0] we, input logic [NC*AW-1:0] a,
                         input logic [NC*DW-1:0] d);
        i_valid = 1'b1;
        i_we    = we;
        i_waddr = a;
        i_wdata = d;
    endtask

    function automatic logic [NC-1:0] exp_we(input logic [NC-1:0] we, input logic [NC*AW-1:0] a);
        logic [NC-1:0] r;
        r[0] = we[0] && (a[4:0] != 5'd0);
        r[1] = we[1] && (a[9:5] != 5'd0);
`ifdef WB_SAME_ADDR_SQUASH_EN
        if (r[0] && r[1] && a[4:0] == a[9:5]) r[0] = 1'b0;
`endif
        return r;
    endfunction

    task automatic do_reset();
        i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
        resetn = 1'b0;
        tick(); tick();
        #2 resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        checks++; if (o_we !== 2'b00) begin errors++; $display("FAIL reset_we got %b exp 00", o_we); end
        checks++; if (o_waddr !== '0 || o_wdata !== '0) begin errors++;
            $display("FAIL reset_payload got %h/%h exp 0/0", o_waddr, o_wdata); end
    endtask

    task automatic test_single();
        i_ready = 1'b1;
        drive(2'b11, {5'd0, 5'd3}, {32'h1111_2222, 32'hDEAD_BEEF});
        tick();
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", o_valid); end
        checks++; if (o_we !== 2'b01) begin errors++; $display("FAIL single_we got %b exp 01", o_we); end
        checks++; if (o_waddr[4:0] !== 5'd3) begin errors++; $display("FAIL single_addr got %0d exp 3", o_waddr[4:0]); end
        checks++; if (o_wdata[31:0] !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL single_data got %h exp deadbeef", o_wdata[31:0]); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", o_valid); end
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b0;
        drive(2'b01, {5'd0, 5'd1}, {32'h0, 32'hA});
        tick();
        checks++; if (o_ready !== 1'b1 || o_wdata[31:0] !== 32'hA) begin errors++;
            $display("FAIL b2b_a_held got rdy=%b d=%h exp rdy=1 d=a", o_ready, o_wdata[31:0]); end
        drive(2'b01, {5'd0, 5'd2}, {32'h0, 32'hB});
        tick();
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b exp 0", o_ready); end
        drive(2'b01, {5'd0, 5'd4}, {32'h0, 32'hC});
        tick();
        checks++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_wdata[31:0] !== 32'hA) begin errors++;
            $display("FAIL b2b_c_blocked got rdy=%b v=%b d=%h exp rdy=0 v=1 d=a", o_ready, o_valid, o_wdata[31:0]); end
        i_ready = 1'b1;
        tick();
        checks++; if (o_valid !== 1'b1 || o_wdata[31:0] !== 32'hB || o_waddr[4:0] !== 5'd2) begin errors++;
            $display("FAIL b2b_out_b got v=%b d=%h a=%0d exp v=1 d=b a=2", o_valid, o_wdata[31:0], o_waddr[4:0]); end
        tick();
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_wdata[31:0] !== 32'hC || o_waddr[4:0] !== 5'd4) begin errors++;
            $display("FAIL b2b_out_c got v=%b d=%h a=%0d exp v=1 d=c a=4", o_valid, o_wdata[31:0], o_waddr[4:0]); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup got %b exp 0", o_valid); end
    endtask

    task automatic fill_full();
        i_ready = 1'b0;
        drive(2'b01, {5'd0, 5'd5}, {32'h0, 32'h55});
        tick();
        drive(2'b01, {5'd0, 5'd6}, {32'h0, 32'h66});
        tick();
        i_valid = 1'b0;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b exp 0", o_ready); end
    endtask

    task automatic test_flush();
        fill_full();
        i_flush = 1'b1; i_ready = 1'b1;
        drive(2'b01, {5'd0, 5'd7}, {32'h0, 32'h77});
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_we !== 2'b00 || o_ready !== 1'b1) begin errors++;
            $display("FAIL flush_state got v=%b we=%b rdy=%b exp 0/00/1", o_valid, o_we, o_ready); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_nothing_out got %b exp 0", o_valid); end
    endtask

    task automatic test_async_reset();
        fill_full();
        #2 resetn = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_we !== 2'b00) begin errors++;
            $display("FAIL async_reset got v=%b rdy=%b we=%b exp 0/1/00", o_valid, o_ready, o_we); end
        checks++; if (o_waddr !== '0 || o_wdata !== '0) begin errors++;
            $display("FAIL async_reset_payload got %h/%h exp 0/0", o_waddr, o_wdata); end
        #2 resetn = 1'b1;
        tick();
    endtask

    task automatic test_same_addr();
        logic [1:0] exp;
`ifdef WB_SAME_ADDR_SQUASH_EN
        exp = 2'b10;
`else
        exp = 2'b11;
`endif
        i_ready = 1'b1;
        drive(2'b11, {5'd7, 5'd7}, {32'h2, 32'h1});
        tick();
        i_valid = 1'b0;
        checks++; if (o_we !== exp) begin errors++; $display("FAIL same_addr_we got %b exp %b", o_we, exp); end
        tick();
    endtask

    task automatic test_random();
        bund_t q[$];
        bund_t b;
        bit acc;
        bit rel;
        acc = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            checks++; if (o_ready !== (q.size() < 2) || o_valid !== (q.size() > 0)) begin errors++;
                $display("FAIL rand_occ c=%0d got rdy=%b v=%b exp occ=%0d", c, o_ready, o_valid, q.size()); end
            acc = i_valid && (q.size() < 2);
            rel = i_ready && (q.size() > 0);
            if (rel) begin
                b = q.pop_front();
                checks++; if (o_we !== b.we || o_waddr !== b.a || o_wdata !== b.d) begin errors++;
                    $display("FAIL rand_data c=%0d got %b/%h/%h exp %b/%h/%h", c, o_we, o_waddr, o_wdata, b.we, b.a, b.d); end
            end
            if (acc) begin
                b.we = exp_we(i_we, i_waddr); b.a = i_waddr; b.d = i_wdata;
                q.push_back(b);
            end
            @(posedge clk); #1;
            if (!i_valid || acc) begin
                i_valid = c < 9990 ? 1'($urandom_range(0, 1)) : 1'b0;
                i_we    = 2'($urandom);
                i_waddr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
                i_wdata = {$urandom, $urandom};
            end
            i_ready = c < 9990 ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        @(negedge clk);
        checks++; if (q.size() != 0 || o_valid !== 1'b0) begin errors++;
            $display("FAIL rand_drain got left=%0d v=%b exp 0/0", q.size(), o_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_same_addr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
